fod_mmd_divider: RTL and testbench

//   Digital multi-modulus divider stage directly downstream of the FOD control word generator.

---
 rtl/fod_mmd_divider.sv | 99 +++++++++
 tb/tb_fod_mmd_divider.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/fod_mmd_divider.sv
// Multi-modulus divider for the FOD path: divides CLK by a per-period modulus
// and holds the retimer select and DTC code aligned to the divided edge.
module fod_mmd_divider #(
    parameter int W_DIV   = 6,
    parameter int W_DTC   = 10,
    parameter int DIV_MIN = 4
) (
    input  logic             CLK,
    input  logic             NRST,
    input  logic             EN,
    input  logic [W_DIV-1:0] MMD_DCW,
    input  logic             RT_DCW,
    input  logic [W_DTC-1:0] DTC_DCW,
    output logic             DIV_OUT,
    output logic             DIV_TC,
    output logic             RT_SEL,
    output logic [W_DTC-1:0] DTC_CODE,
    output logic [W_DIV-1:0] N_CUR,
    output logic             CLAMP_FLAG
);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [W_DIV-1:0] DIV_MIN_W = W_DIV'(DIV_MIN);
    localparam logic [W_DIV-1:0] ONE_W     = {{(W_DIV-1){1'b0}}, 1'b1};

    state_t             state_q;
    logic [W_DIV-1:0]   cnt_q;
    logic [W_DIV-1:0]   n_cur_q;
    logic               rt_sel_q;
    logic [W_DTC-1:0]   dtc_code_q;
    logic               div_tc_q;
    logic               div_out_q;
    logic               clamp_q;

    logic               below_min_s;
    logic [W_DIV-1:0]   nc_s;
    logic               ld_s;
    logic [W_DIV-1:0]   cnt_dec_s;
    logic               out_d;

    // Clamp the request, detect the period boundary and precompute the next output level
    always_comb begin
        below_min_s = (MMD_DCW < DIV_MIN_W);
        if (below_min_s) begin
            nc_s = DIV_MIN_W;
        end else begin
            nc_s = MMD_DCW;
        end
        ld_s      = EN & ((state_q == IDLE) | ((state_q == RUN) & (cnt_q == ONE_W)));
        cnt_dec_s = cnt_q - ONE_W;
        out_d     = (cnt_dec_s > (n_cur_q >> 1));
    end

    // Divider state, period counter and per-period captured controls; EN low overrides a load
    always_ff @(posedge CLK or negedge NRST) begin
        if (!NRST) begin
            state_q    <= IDLE;
            cnt_q      <= {W_DIV{1'b0}};
            n_cur_q    <= DIV_MIN_W;
            rt_sel_q   <= 1'b0;
            dtc_code_q <= {W_DTC{1'b0}};
            div_tc_q   <= 1'b0;
            div_out_q  <= 1'b0;
            clamp_q    <= 1'b0;
        end else if (!EN) begin
            state_q   <= IDLE;
            cnt_q     <= {W_DIV{1'b0}};
            div_tc_q  <= 1'b0;
            div_out_q <= 1'b0;
        end else if (ld_s) begin
            state_q    <= RUN;
            cnt_q      <= nc_s;
            n_cur_q    <= nc_s;
            rt_sel_q   <= RT_DCW;
            dtc_code_q <= DTC_DCW;
            div_tc_q   <= 1'b1;
            div_out_q  <= 1'b1;
            if (below_min_s) begin
                clamp_q <= 1'b1;
            end
        end else begin
            cnt_q     <= cnt_dec_s;
            div_tc_q  <= 1'b0;
            div_out_q <= out_d;
        end
    end

    assign DIV_OUT    = div_out_q;
    assign DIV_TC     = div_tc_q;
    assign RT_SEL     = rt_sel_q;
    assign DTC_CODE   = dtc_code_q;
    assign N_CUR      = n_cur_q;
    assign CLAMP_FLAG = clamp_q;

endmodule

// File: tb/tb_fod_mmd_divider.sv
// Directed bench for fod_mmd_divider: period length, duty, sampling alignment,
// clamping, EN drop/reassert and asynchronous reset.
module tb_fod_mmd_divider;

    logic       CLK = 1'b0;
    logic       NRST;
    logic       EN;
    logic [5:0] MMD_DCW;
    logic       RT_DCW;
    logic [9:0] DTC_DCW;
    logic       DIV_OUT;
    logic       DIV_TC;
    logic       RT_SEL;
    logic [9:0] DTC_CODE;
    logic [5:0] N_CUR;
    logic       CLAMP_FLAG;

    int n_tests = 0;
    int n_fail  = 0;

    fod_mmd_divider dut (
        .CLK        (CLK),
        .NRST       (NRST),
        .EN         (EN),
        .MMD_DCW    (MMD_DCW),
        .RT_DCW     (RT_DCW),
        .DTC_DCW    (DTC_DCW),
        .DIV_OUT    (DIV_OUT),
        .DIV_TC     (DIV_TC),
        .RT_SEL     (RT_SEL),
        .DTC_CODE   (DTC_CODE),
        .N_CUR      (N_CUR),
        .CLAMP_FLAG (CLAMP_FLAG)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Called on the sample just after a load edge; walks one full period of n cycles.
    // Mid-period it writes junk to MMD_DCW, then at cnt==3 the real next-period controls.
    task automatic run_period(input int n, input logic [5:0] nxt_mmd, input logic nxt_rt,
                              input logic [9:0] nxt_dtc, input logic exp_rt, input logic [9:0] exp_dtc);
        int hi = 0;
        int tcs = 0;
        int tr = 0;
        int bad = 0;
        logic prev;
        check("n_cur", N_CUR, n);
        prev = DIV_OUT;
        for (int i = 0; i < n; i++) begin
            hi  += int'(DIV_OUT);
            tcs += int'(DIV_TC);
            if (i > 0 && DIV_OUT !== prev) tr++;
            prev = DIV_OUT;
            if (RT_SEL !== exp_rt || DTC_CODE !== exp_dtc) bad++;
            if (i == 1) MMD_DCW = 6'd63 - nxt_mmd;
            if (i == n - 3) begin
                MMD_DCW = nxt_mmd;
                RT_DCW  = nxt_rt;
                DTC_DCW = nxt_dtc;
            end
            tick();
        end
        check("high_cycles", hi, (n + 1) / 2);
        check("tc_per_period", tcs, 1);
        check("out_edges", tr, 1);
        check("ctrl_hold", bad, 0);
        check("next_tc", DIV_TC, 1'b1);
        check("next_rise", DIV_OUT, 1'b1);
    endtask

    initial begin
        NRST    = 1'b0;
        EN      = 1'b0;
        MMD_DCW = 6'd8;
        RT_DCW  = 1'b0;
        DTC_DCW = 10'h155;
        #12;
        check("rst_out", DIV_OUT, 1'b0);
        check("rst_tc", DIV_TC, 1'b0);
        check("rst_rt", RT_SEL, 1'b0);
        check("rst_dtc", DTC_CODE, 10'h000);
        check("rst_ncur", N_CUR, 6'd4);
        check("rst_clamp", CLAMP_FLAG, 1'b0);

        NRST = 1'b1;
        tick();
        check("idle_out", DIV_OUT, 1'b0);
        EN = 1'b1;
        tick();
        check("first_tc", DIV_TC, 1'b1);
        check("first_out", DIV_OUT, 1'b1);
        check("first_dtc", DTC_CODE, 10'h155);

        run_period(8, 6'd8, 1'b0, 10'h155, 1'b0, 10'h155);
        run_period(8, 6'd9, 1'b1, 10'h3FF, 1'b0, 10'h155);
        check("dtc_new", DTC_CODE, 10'h3FF);
        check("rt_new", RT_SEL, 1'b1);
        run_period(9, 6'd8, 1'b1, 10'h3FF, 1'b1, 10'h3FF);
        run_period(8, 6'd5, 1'b1, 10'h3FF, 1'b1, 10'h3FF);
        run_period(5, 6'd63, 1'b1, 10'h3FF, 1'b1, 10'h3FF);
        check("clamp_before", CLAMP_FLAG, 1'b0);
        run_period(63, 6'd2, 1'b1, 10'h3FF, 1'b1, 10'h3FF);
        check("clamp_set", CLAMP_FLAG, 1'b1);
        run_period(4, 6'd8, 1'b1, 10'h3FF, 1'b1, 10'h3FF);
        run_period(8, 6'd8, 1'b1, 10'h3FF, 1'b1, 10'h3FF);
        check("clamp_sticky", CLAMP_FLAG, 1'b1);

        // Drop EN at cnt==3 (five cycles into an 8-cycle period)
        for (int i = 0; i < 5; i++) tick();
        EN = 1'b0;
        tick();
        check("drop_out", DIV_OUT, 1'b0);
        check("drop_tc", DIV_TC, 1'b0);
        check("drop_dtc", DTC_CODE, 10'h3FF);
        check("drop_rt", RT_SEL, 1'b1);
        check("drop_ncur", N_CUR, 6'd8);
        tick();
        check("idle_hold", DIV_OUT, 1'b0);
        MMD_DCW = 6'd6;
        EN = 1'b1;
        tick();
        check("reen_tc", DIV_TC, 1'b1);
        run_period(6, 6'd6, 1'b1, 10'h3FF, 1'b1, 10'h3FF);

        // EN falls on the cnt==1 edge: no load
        for (int i = 0; i < 5; i++) tick();
        EN = 1'b0;
        tick();
        check("race_tc", DIV_TC, 1'b0);
        check("race_out", DIV_OUT, 1'b0);
        EN = 1'b1;
        tick();
        check("race_reen_tc", DIV_TC, 1'b1);

        tick();
        tick();
        NRST = 1'b0;
        #1;
        check("arst_out", DIV_OUT, 1'b0);
        check("arst_dtc", DTC_CODE, 10'h000);
        check("arst_rt", RT_SEL, 1'b0);
        check("arst_ncur", N_CUR, 6'd4);
        check("arst_clamp", CLAMP_FLAG, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
